// File: rtl/siganfu_barrel_thermal.sv
// Barrel heat model: accumulates heat per detected shot, cools on a prescaled tick,
// and reports NORMAL/WARM/OVERHEAT with hysteresis and a minimum cooling dwell.
module siganfu_barrel_thermal #(
  parameter int HEAT_W        = 8,
  parameter int HEAT_PER_SHOT = 12,
  parameter int COOL_RATE     = 1,
  parameter int COOL_DIV      = 16,
  parameter int WARN_LIMIT    = 150,
  parameter int HOT_LIMIT     = 200,
  parameter int SAFE_LIMIT    = 80,
  parameter int MIN_COOL      = 100
) (
  input  logic              sysclk,
  input  logic              reboot_n,
  input  logic              fire_trigger,
  output logic [HEAT_W-1:0] heat_level,
  output logic              overheat_sensor,
  output logic              warm_warning,
  output logic [1:0]        thermal_state,
  output logic [15:0]       shot_count,
  output logic              hot_fire_fault
);

  localparam int SUM_W = HEAT_W + 1;
  localparam int PRE_W = (COOL_DIV > 1) ? $clog2(COOL_DIV) : 1;
  localparam int TMR_W = $clog2(MIN_COOL + 1);

  localparam logic [SUM_W-1:0]  SHOT_ADD = SUM_W'(HEAT_PER_SHOT);
  localparam logic [SUM_W-1:0]  COOL_SUB = SUM_W'(COOL_RATE);
  localparam logic [HEAT_W-1:0] HOT_L    = HEAT_W'(HOT_LIMIT);
  localparam logic [HEAT_W-1:0] WARN_L   = HEAT_W'(WARN_LIMIT);
  localparam logic [HEAT_W-1:0] SAFE_L   = HEAT_W'(SAFE_LIMIT);
  localparam logic [PRE_W-1:0]  PRE_LAST = PRE_W'(COOL_DIV - 1);
  localparam logic [TMR_W-1:0]  TMR_MAX  = TMR_W'(MIN_COOL);

  typedef enum logic [1:0] {
    ST_NORMAL   = 2'b00,
    ST_WARM     = 2'b01,
    ST_OVERHEAT = 2'b10
  } state_t;

  state_t             state_r;
  state_t             state_next_s;
  logic               fire_q_r;
  logic [PRE_W-1:0]   presc_r;
  logic [TMR_W-1:0]   cool_tmr_r;
  logic [HEAT_W-1:0]  heat_r;
  logic [HEAT_W-1:0]  heat_next_s;
  logic [SUM_W-1:0]   sum_s;
  logic               shot_s;
  logic               tick_s;

  // Clamp a one-bit-wider intermediate heat value to the accumulator range.
  function automatic logic [HEAT_W-1:0] sat_heat(input logic [SUM_W-1:0] val);
    if (val[SUM_W-1]) begin
      sat_heat = {HEAT_W{1'b1}};
    end else begin
      sat_heat = val[HEAT_W-1:0];
    end
  endfunction

  assign shot_s     = fire_trigger & ~fire_q_r;
  assign tick_s     = (presc_r == PRE_LAST);
  assign heat_level = heat_r;

  // Heat update: add shot heat, then remove cooling with a floor at zero.
  always_comb begin
    sum_s = {1'b0, heat_r} + (shot_s ? SHOT_ADD : {SUM_W{1'b0}});
    if (tick_s) begin
      if (sum_s < COOL_SUB) begin
        sum_s = {SUM_W{1'b0}};
      end else begin
        sum_s = sum_s - COOL_SUB;
      end
    end else begin
      sum_s = sum_s;
    end
    heat_next_s = sat_heat(sum_s);
  end

  // Next-state decision, evaluated on the heat value about to be registered.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_NORMAL: begin
        if (heat_next_s >= HOT_L) begin
          state_next_s = ST_OVERHEAT;
        end else if (heat_next_s >= WARN_L) begin
          state_next_s = ST_WARM;
        end else begin
          state_next_s = ST_NORMAL;
        end
      end
      ST_WARM: begin
        if (heat_next_s >= HOT_L) begin
          state_next_s = ST_OVERHEAT;
        end else if (heat_next_s < WARN_L) begin
          state_next_s = ST_NORMAL;
        end else begin
          state_next_s = ST_WARM;
        end
      end
      ST_OVERHEAT: begin
        if ((cool_tmr_r == TMR_MAX) && (heat_next_s <= SAFE_L)) begin
          state_next_s = ST_NORMAL;
        end else begin
          state_next_s = ST_OVERHEAT;
        end
      end
      default: state_next_s = ST_NORMAL;
    endcase
  end

  // State, counters and registered output decodes.
  always_ff @(posedge sysclk or negedge reboot_n) begin
    if (!reboot_n) begin
      fire_q_r        <= 1'b0;
      presc_r         <= {PRE_W{1'b0}};
      cool_tmr_r      <= {TMR_W{1'b0}};
      heat_r          <= {HEAT_W{1'b0}};
      state_r         <= ST_NORMAL;
      overheat_sensor <= 1'b0;
      warm_warning    <= 1'b0;
      thermal_state   <= 2'b00;
      shot_count      <= 16'h0000;
      hot_fire_fault  <= 1'b0;
    end else begin
      fire_q_r <= fire_trigger;
      presc_r  <= tick_s ? {PRE_W{1'b0}} : presc_r + PRE_W'(1);
      heat_r   <= heat_next_s;
      state_r  <= state_next_s;
      // Dwell timer restarts on every entry to OVERHEAT and holds at its ceiling.
      if ((state_r != ST_OVERHEAT) && (state_next_s == ST_OVERHEAT)) begin
        cool_tmr_r <= {TMR_W{1'b0}};
      end else if ((state_r == ST_OVERHEAT) && (cool_tmr_r != TMR_MAX)) begin
        cool_tmr_r <= cool_tmr_r + TMR_W'(1);
      end else begin
        cool_tmr_r <= cool_tmr_r;
      end
      shot_count      <= shot_s ? shot_count + 16'h0001 : shot_count;
      hot_fire_fault  <= hot_fire_fault | (shot_s & (state_r == ST_OVERHEAT));
      overheat_sensor <= (state_next_s == ST_OVERHEAT);
      warm_warning    <= (state_next_s == ST_WARM);
      thermal_state   <= state_next_s;
    end
  end

endmodule

// File: tb/tb_siganfu_barrel_thermal.sv
// Self-checking bench for siganfu_barrel_thermal: cycle model feeds a scoreboard,
// scenario tasks add targeted checks.
module tb_siganfu_barrel_thermal;

  logic        sysclk = 1'b0;
  logic        reboot_n = 1'b0;
  logic        fire_trigger = 1'b0;
  logic [7:0]  heat_level;
  logic        overheat_sensor;
  logic        warm_warning;
  logic [1:0]  thermal_state;
  logic [15:0] shot_count;
  logic        hot_fire_fault;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [7:0]  heat;
    logic [1:0]  st;
    logic [15:0] cnt;
    logic        fault;
  } exp_t;

  exp_t sb_q[$];
  exp_t e_cur;

  int m_heat = 0;
  int m_st = 0;
  int m_tmr = 0;
  int m_presc = 0;
  int m_cnt = 0;
  bit m_fq = 1'b0;
  bit m_fault = 1'b0;

  siganfu_barrel_thermal dut (
    .sysclk          (sysclk),
    .reboot_n        (reboot_n),
    .fire_trigger    (fire_trigger),
    .heat_level      (heat_level),
    .overheat_sensor (overheat_sensor),
    .warm_warning    (warm_warning),
    .thermal_state   (thermal_state),
    .shot_count      (shot_count),
    .hot_fire_fault  (hot_fire_fault)
  );

  always #5 sysclk = ~sysclk;

  // Reference model: one step per rising edge, expected outputs go to the scoreboard.
  always @(posedge sysclk or negedge reboot_n) begin
    if (!reboot_n) begin
      m_heat  <= 0;
      m_st    <= 0;
      m_tmr   <= 0;
      m_presc <= 0;
      m_cnt   <= 0;
      m_fq    <= 1'b0;
      m_fault <= 1'b0;
      sb_q.delete();
    end else begin
      bit   shot;
      bit   tick;
      int   h;
      int   ns;
      exp_t e;
      shot = fire_trigger && !m_fq;
      tick = (m_presc == 15);
      h = m_heat + (shot ? 12 : 0) - (tick ? 1 : 0);
      if (h < 0) h = 0;
      if (h > 255) h = 255;
      ns = m_st;
      if (m_st == 0) begin
        if (h >= 200) ns = 2; else if (h >= 150) ns = 1;
      end else if (m_st == 1) begin
        if (h >= 200) ns = 2; else if (h < 150) ns = 0;
      end else begin
        if (m_tmr == 100 && h <= 80) ns = 0;
      end
      if (m_st != 2 && ns == 2) m_tmr <= 0;
      else if (m_st == 2 && m_tmr < 100) m_tmr <= m_tmr + 1;
      if (m_st == 2 && shot) m_fault <= 1'b1;
      e.heat  = h[7:0];
      e.st    = ns[1:0];
      e.cnt   = shot ? 16'(m_cnt + 1) : 16'(m_cnt);
      e.fault = m_fault | (m_st == 2 && shot);
      m_cnt   <= shot ? (m_cnt + 1) % 65536 : m_cnt;
      m_presc <= tick ? 0 : m_presc + 1;
      m_fq    <= fire_trigger;
      m_heat  <= h;
      m_st    <= ns;
      sb_q.push_back(e);
    end
  end

  // Scoreboard: compare every registered output on the falling edge.
  always @(negedge sysclk) begin
    if (reboot_n && sb_q.size() != 0) begin
      e_cur = sb_q.pop_front();
      n_tests++;
      if (heat_level !== e_cur.heat || thermal_state !== e_cur.st ||
          shot_count !== e_cur.cnt || hot_fire_fault !== e_cur.fault ||
          overheat_sensor !== (e_cur.st == 2'b10) || warm_warning !== (e_cur.st == 2'b01)) begin
        n_fail++;
        $display("FAIL scoreboard t=%0t got heat=%0d st=%b cnt=%0d flt=%b ovh=%b warm=%b want heat=%0d st=%b cnt=%0d flt=%b",
                 $time, heat_level, thermal_state, shot_count, hot_fire_fault, overheat_sensor,
                 warm_warning, e_cur.heat, e_cur.st, e_cur.cnt, e_cur.fault);
      end
    end
  end

  task automatic test_reset();
    fire_trigger = 1'b0;
    @(negedge sysclk);
    #2 reboot_n = 1'b0;
    #1;
    n_tests++;
    if ({heat_level, overheat_sensor, warm_warning, thermal_state, shot_count, hot_fire_fault} !== 29'd0) begin
      n_fail++;
      $display("FAIL reset_outputs got heat=%0d st=%b cnt=%0d flt=%b want all zero",
               heat_level, thermal_state, shot_count, hot_fire_fault);
    end
    @(negedge sysclk);
    #2 reboot_n = 1'b1;
    repeat (64) @(negedge sysclk);
    n_tests++;
    if (heat_level !== 8'd0 || thermal_state !== 2'b00 || overheat_sensor !== 1'b0 ||
        warm_warning !== 1'b0 || hot_fire_fault !== 1'b0 || shot_count !== 16'd0) begin
      n_fail++;
      $display("FAIL idle_64 got heat=%0d st=%b cnt=%0d want heat=0 st=00 cnt=0",
               heat_level, thermal_state, shot_count);
    end
  endtask

  task automatic test_held_level();
    @(negedge sysclk);
    #2 reboot_n = 1'b0;
    fire_trigger = 1'b1;
    @(negedge sysclk);
    #2 reboot_n = 1'b1;
    @(posedge sysclk);
    #1;
    n_tests++;
    if (heat_level !== 8'd12 || shot_count !== 16'd1) begin
      n_fail++;
      $display("FAIL held_first got heat=%0d cnt=%0d want heat=12 cnt=1", heat_level, shot_count);
    end
    repeat (39) @(posedge sysclk);
    #1;
    n_tests++;
    if (heat_level !== 8'd10 || shot_count !== 16'd1) begin
      n_fail++;
      $display("FAIL held_40 got heat=%0d cnt=%0d want heat=10 cnt=1", heat_level, shot_count);
    end
    @(negedge sysclk);
    fire_trigger = 1'b0;
  endtask

  task automatic test_ramp();
    bit seen_warm = 1'b0;
    bit seen_ovh  = 1'b0;
    @(negedge sysclk);
    #2 reboot_n = 1'b0;
    fire_trigger = 1'b0;
    @(negedge sysclk);
    #2 reboot_n = 1'b1;
    for (int i = 0; i < 34; i++) begin
      @(negedge sysclk);
      if (thermal_state == 2'b01 && !seen_warm) begin
        seen_warm = 1'b1;
        n_tests++;
        if (heat_level < 8'd150 || heat_level >= 8'd200) begin
          n_fail++;
          $display("FAIL warm_entry got heat=%0d want 150..199", heat_level);
        end
      end
      if (thermal_state == 2'b10 && !seen_ovh) begin
        seen_ovh = 1'b1;
        n_tests++;
        if (heat_level < 8'd200 || overheat_sensor !== 1'b1) begin
          n_fail++;
          $display("FAIL ovh_entry got heat=%0d sensor=%b want heat>=200 sensor=1",
                   heat_level, overheat_sensor);
        end
      end
      fire_trigger = (i % 2 == 0) ? 1'b1 : 1'b0;
    end
    @(negedge sysclk);
    n_tests++;
    if (shot_count !== 16'd17 || overheat_sensor !== 1'b1 || !seen_warm || !seen_ovh ||
        hot_fire_fault !== 1'b0) begin
      n_fail++;
      $display("FAIL ramp_end got cnt=%0d sensor=%b warm_seen=%b flt=%b want cnt=17 sensor=1 warm_seen=1 flt=0",
               shot_count, overheat_sensor, seen_warm, hot_fire_fault);
    end
  endtask

  task automatic test_hot_fire();
    @(negedge sysclk);
    fire_trigger = 1'b1;
    @(negedge sysclk);
    fire_trigger = 1'b0;
    n_tests++;
    if (hot_fire_fault !== 1'b1 || shot_count !== 16'd18 || thermal_state !== 2'b10) begin
      n_fail++;
      $display("FAIL hot_fire got flt=%b cnt=%0d st=%b want flt=1 cnt=18 st=10",
               hot_fire_fault, shot_count, thermal_state);
    end
  endtask

  task automatic test_cooldown();
    int  ovh_cycles = 0;
    bit  released = 1'b0;
    for (int i = 0; i < 5000 && !released; i++) begin
      @(negedge sysclk);
      if (thermal_state == 2'b00) begin
        released = 1'b1;
      end else begin
        ovh_cycles++;
        if (thermal_state !== 2'b10) begin
          n_tests++;
          n_fail++;
          $display("FAIL cool_hold got st=%b heat=%0d want st=10", thermal_state, heat_level);
        end
      end
    end
    n_tests++;
    if (!released || heat_level !== 8'd80 || ovh_cycles < 100 || overheat_sensor !== 1'b0 ||
        hot_fire_fault !== 1'b1) begin
      n_fail++;
      $display("FAIL cool_release got released=%b heat=%0d cycles=%0d sensor=%b flt=%b want released=1 heat=80 cycles>=100 sensor=0 flt=1",
               released, heat_level, ovh_cycles, overheat_sensor, hot_fire_fault);
    end
  endtask

  task automatic test_coincident_sat();
    bit aligned = 1'b0;
    @(negedge sysclk);
    #2 reboot_n = 1'b0;
    fire_trigger = 1'b0;
    @(negedge sysclk);
    #2 reboot_n = 1'b1;
    n_tests++;
    if (hot_fire_fault !== 1'b0) begin
      n_fail++;
      $display("FAIL fault_cleared got flt=%b want 0", hot_fire_fault);
    end
    for (int i = 0; i < 18; i++) begin
      @(negedge sysclk);
      fire_trigger = (i % 2 == 0) ? 1'b1 : 1'b0;
    end
    for (int i = 0; i < 400 && !aligned; i++) begin
      @(negedge sysclk);
      if (m_heat == 100 && m_presc == 15) aligned = 1'b1;
    end
    n_tests++;
    if (!aligned) begin
      n_fail++;
      $display("FAIL align_timeout got aligned=0 want 1");
    end
    fire_trigger = 1'b1;
    @(posedge sysclk);
    #1;
    n_tests++;
    if (heat_level !== 8'd111) begin
      n_fail++;
      $display("FAIL shot_plus_tick got heat=%0d want 111", heat_level);
    end
    @(negedge sysclk);
    fire_trigger = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge sysclk);
      fire_trigger = (i % 2 == 0) ? 1'b1 : 1'b0;
    end
    @(negedge sysclk);
    n_tests++;
    if (heat_level !== 8'd255 || hot_fire_fault !== 1'b1 || overheat_sensor !== 1'b1) begin
      n_fail++;
      $display("FAIL saturate got heat=%0d flt=%b sensor=%b want heat=255 flt=1 sensor=1",
               heat_level, hot_fire_fault, overheat_sensor);
    end
  endtask

  task automatic test_reset_mid_overheat();
    @(negedge sysclk);
    #2 reboot_n = 1'b0;
    #1;
    n_tests++;
    if ({heat_level, overheat_sensor, warm_warning, thermal_state, shot_count, hot_fire_fault} !== 29'd0) begin
      n_fail++;
      $display("FAIL mid_reset got heat=%0d st=%b cnt=%0d flt=%b want all zero",
               heat_level, thermal_state, shot_count, hot_fire_fault);
    end
    @(negedge sysclk);
    #2 reboot_n = 1'b1;
    @(posedge sysclk);
    #1;
    n_tests++;
    if (heat_level !== 8'd0 || thermal_state !== 2'b00 || shot_count !== 16'd0 || hot_fire_fault !== 1'b0) begin
      n_fail++;
      $display("FAIL cold_restart got heat=%0d st=%b cnt=%0d flt=%b want 0 00 0 0",
               heat_level, thermal_state, shot_count, hot_fire_fault);
    end
    repeat (20) @(negedge sysclk);
  endtask

  initial begin
    test_reset();
    test_held_level();
    test_ramp();
    test_hot_fire();
    test_cooldown();
    test_coincident_sat();
    test_reset_mid_overheat();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
